// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencing controller: load-use bubble, branch flush, MDU occupancy of EX, memory-wait freeze.
// Optional HAZARD_PERF_CNT_EN adds saturating stall_cycles / flush_count counters.
module hazard_ctrl_unit #(
  parameter int REGISTER_BITS = 5,
  parameter int MDU_LAT       = 4,
  parameter int CNT_W         = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REGISTER_BITS-1:0] IF_ID_RS,
  input  logic [REGISTER_BITS-1:0] IF_ID_RT,
  input  logic [REGISTER_BITS-1:0] ID_EX_RT,
  input  logic                     ID_EX_MemRead,
  input  logic                     ID_mdu_start,
  input  logic                     EX_branch_taken,
  input  logic                     MEM_stall,
  output logic                     PC_write,
  output logic                     IF_ID_write,
  output logic                     ID_EX_write,
  output logic                     IF_ID_flush,
  output logic                     ID_EX_flush,
  output logic                     EX_MEM_bubble,
  output logic                     mdu_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              flush_count
`endif
);

  typedef enum logic [1:0] {RUN, MDU_BUSY, MDU_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ldu;
  logic             mdu_release;

  assign ldu = ID_EX_MemRead && (ID_EX_RT != '0) &&
               ((ID_EX_RT == IF_ID_RS) || (ID_EX_RT == IF_ID_RT));

  // MDU result may leave EX once the count is spent and memory is not holding EX/MEM.
  assign mdu_release = ((state == MDU_BUSY && cnt == '0) || state == MDU_DONE) && !MEM_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!MEM_stall && !EX_branch_taken && !ldu && ID_mdu_start) begin
            state <= MDU_BUSY;
            cnt   <= CNT_W'(MDU_LAT - 2);
          end
        end
        MDU_BUSY: begin
          if (cnt != '0)     cnt   <= cnt - 1'b1;
          else if (MEM_stall) state <= MDU_DONE;
          else               state <= RUN;
        end
        MDU_DONE: begin
          if (!MEM_stall) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    PC_write      = 1'b1;
    IF_ID_write   = 1'b1;
    ID_EX_write   = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_flush   = 1'b0;
    EX_MEM_bubble = 1'b0;
    mdu_busy      = 1'b0;
    if (rst) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_write = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (MEM_stall) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_write = 1'b0;
          end else if (EX_branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
          end else if (ldu) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
          end
        end
        MDU_BUSY, MDU_DONE: begin
          mdu_busy = 1'b1;
          if (!mdu_release) begin
            PC_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_write   = 1'b0;
            EX_MEM_bubble = (state == MDU_BUSY);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!PC_write && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (IF_ID_flush && flush_count != '1) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios plus randomized traffic
// against a cycle-age reference model.
module tb_hazard_ctrl_unit;
  localparam int RB  = 5;
  localparam int LAT = 4;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [RB-1:0] rs, rt, ex_rt;
  logic          memrd, mdu_start, br, mstall;
  logic          pc_w, ifid_w, idex_w, ifid_f, idex_f, exmem_b, busy;
  logic [6:0]    act;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   stall_cycles, flush_count;
`endif

  hazard_ctrl_unit #(.REGISTER_BITS(RB), .MDU_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_RS(rs), .IF_ID_RT(rt), .ID_EX_RT(ex_rt),
    .ID_EX_MemRead(memrd), .ID_mdu_start(mdu_start),
    .EX_branch_taken(br), .MEM_stall(mstall),
    .PC_write(pc_w), .IF_ID_write(ifid_w), .ID_EX_write(idex_w),
    .IF_ID_flush(ifid_f), .ID_EX_flush(idex_f),
    .EX_MEM_bubble(exmem_b), .mdu_busy(busy)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  assign act = {pc_w, ifid_w, idex_w, ifid_f, idex_f, exmem_b, busy};

  int          n_cmp = 0;
  int          n_err = 0;
  int          age   = 0;   // cycles the MDU op has been in EX; 0 = no MDU op
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;

  function automatic bit ldu_m();
    return memrd && ex_rt != 0 && (ex_rt == rs || ex_rt == rt);
  endfunction

  // Expected {PC_w, IFID_w, IDEX_w, IFID_flush, IDEX_flush, EXMEM_bubble, mdu_busy}
  function automatic logic [6:0] model_exp();
    if (rst) return 7'b0000000;
    if (age > 0) begin
      if (age >= LAT - 1 && !mstall) return 7'b1110001;
      return {5'b00000, (age <= LAT - 1), 1'b1};
    end
    if (mstall)  return 7'b0000000;
    if (br)      return 7'b1111100;
    if (ldu_m()) return 7'b0010100;
    return 7'b1110000;
  endfunction

  task automatic tick();
    logic [6:0] e;
    e = model_exp();
    @(posedge clk);
    if (rst) begin
      age = 0; m_stall = '0; m_flush = '0;
    end else begin
      if (!e[6] && m_stall != '1) m_stall = m_stall + 1;
      if (e[3] && m_flush != '1)  m_flush = m_flush + 1;
      if (age > 0) begin
        if (age >= LAT - 1 && !mstall) age = 0;
        else age = age + 1;
      end else if (!mstall && !br && !ldu_m() && mdu_start) age = 1;
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; rs = 0; rt = 0; ex_rt = 0; memrd = 0; mdu_start = 0; br = 0; mstall = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; mdu_start = 1; memrd = 1; ex_rt = 3; rs = 3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); n_cmp++;
      if (act !== 7'b0000000) begin n_err++; $display("FAIL reset_hold c%0d: got %b want 0000000", i, act); end
      tick();
    end
    idle();
    @(negedge clk); n_cmp++;
    if (act !== 7'b1110000) begin n_err++; $display("FAIL reset_release: got %b want 1110000", act); end
    tick();
  endtask

  task automatic test_mdu();
    int nb = 0, nw = 0, nbub = 0;
    idle(); mdu_start = 1;
    @(negedge clk); n_cmp++;
    if (act !== model_exp()) begin n_err++; $display("FAIL mdu_issue: got %b want %b", act, model_exp()); end
    tick(); idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); n_cmp++;
      if (act !== model_exp()) begin n_err++; $display("FAIL mdu_seq c%0d: got %b want %b", i, act, model_exp()); end
      nb += busy; nw += !pc_w; nbub += exmem_b;
      tick();
    end
    n_cmp++;
    if (nb != LAT - 1 || nw != 2 || nbub != 2) begin
      n_err++; $display("FAIL mdu_counts: got busy=%0d wr0=%0d bub=%0d want 3/2/2", nb, nw, nbub);
    end
`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk); n_cmp++;
    if (stall_cycles !== 32'd2 || flush_count !== 32'd0) begin
      n_err++; $display("FAIL perf_mdu: got %0d/%0d want 2/0", stall_cycles, flush_count);
    end
`endif
  endtask

  task automatic test_load_use();
    idle(); memrd = 1; ex_rt = 5; rs = 5;
    @(negedge clk); n_cmp++;
    if (act !== 7'b0010100) begin n_err++; $display("FAIL ldu_stall: got %b want 0010100", act); end
    tick(); idle();
    @(negedge clk); n_cmp++;
    if (act !== 7'b1110000) begin n_err++; $display("FAIL ldu_one_bubble: got %b want 1110000", act); end
    tick();
    memrd = 1; ex_rt = 0; rs = 0; rt = 0;
    @(negedge clk); n_cmp++;
    if (act !== 7'b1110000) begin n_err++; $display("FAIL ldu_r0: got %b want 1110000", act); end
    tick();
    memrd = 1; ex_rt = 9; rs = 2; rt = 9;
    @(negedge clk); n_cmp++;
    if (act !== 7'b0010100) begin n_err++; $display("FAIL ldu_rt: got %b want 0010100", act); end
    tick(); idle();
  endtask

  task automatic test_branch_priority();
    idle(); br = 1; memrd = 1; ex_rt = 7; rs = 7; mdu_start = 1;
    @(negedge clk); n_cmp++;
    if (act !== 7'b1111100) begin n_err++; $display("FAIL br_prio: got %b want 1111100", act); end
    tick(); idle();
    @(negedge clk); n_cmp++;
    if (act !== 7'b1110000) begin n_err++; $display("FAIL br_discard_mdu: got %b want 1110000", act); end
    tick();
    br = 1; mstall = 1;
    @(negedge clk); n_cmp++;
    if (act !== 7'b0000000) begin n_err++; $display("FAIL stall_over_br: got %b want 0000000", act); end
    tick(); idle();
  endtask

  task automatic test_mdu_mem_stall();
    logic [6:0] want [6] = '{7'b0000011, 7'b0000011, 7'b0000011, 7'b0000001, 7'b1110001, 7'b1110000};
    idle(); mdu_start = 1;
    tick(); idle();
    for (int i = 0; i < 6; i++) begin
      mstall = (i >= 1 && i <= 3);
      @(negedge clk); n_cmp++;
      if (act !== want[i] || act !== model_exp()) begin
        n_err++; $display("FAIL mdu_memstall c%0d: got %b want %b", i, act, want[i]);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid_mdu();
    idle(); mdu_start = 1;
    tick(); idle();
    tick();
    rst = 1;
    @(negedge clk); n_cmp++;
    if (act !== 7'b0000000) begin n_err++; $display("FAIL rst_mid_mdu: got %b want 0000000", act); end
    tick(); idle();
    @(negedge clk); n_cmp++;
    if (act !== 7'b1110000) begin n_err++; $display("FAIL rst_mid_mdu_after: got %b want 1110000", act); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      rs        = RB'($urandom_range(0, 3));
      rt        = RB'($urandom_range(0, 3));
      ex_rt     = RB'($urandom_range(0, 3));
      memrd     = $urandom_range(0, 1) == 1;
      mdu_start = ($urandom_range(0, 3) == 0);
      br        = ($urandom_range(0, 5) == 0);
      mstall    = ($urandom_range(0, 3) == 0);
      @(negedge clk); n_cmp++;
      if (act !== model_exp()) begin n_err++; $display("FAIL random c%0d: got %b want %b", i, act, model_exp()); end
`ifdef HAZARD_PERF_CNT_EN
      n_cmp++;
      if (stall_cycles !== m_stall || flush_count !== m_flush) begin
        n_err++; $display("FAIL perf_random c%0d: got %0d/%0d want %0d/%0d", i, stall_cycles, flush_count, m_stall, m_flush);
      end
`endif
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    @(posedge clk); #1;
    test_reset();
    test_mdu();
    test_load_use();
    test_branch_priority();
    test_mdu_mem_stall();
    test_reset_mid_mdu();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
